cordic_arbiter: RTL
===================

# cordic_arbiter

Shares the single two-channel vectoring CORDIC among NREQ requesters, such as the surface-normal, lighting and projection stages of the donut renderer. It takes one operand set at a time over valid/ready, launches the CORDIC with a one-cycle start, and waits for its done flag. It then captures both scaled magnitudes into a response register tagged with the requester index. At most one operation is in flight.

## Interface
- NREQ, 3: number of requesters, 2..8
- W, 16: operand and result width; signed two's complement
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_x, req_y, req_x2, req_y2  in  NREQ*W each  packed operands; requester i occupies bits [i*W +: W]
- rsp_valid  out  1  result register full
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result
- rsp_xout, rsp_x2out  out  W each  captured CORDIC outputs
- cordic_start  out  1  CORDIC load strobe
- cordic_xin, cordic_yin, cordic_x2in, cordic_y2in  out  W each  CORDIC operands
- cordic_xout, cordic_x2out  in  W each  CORDIC scaled magnitudes
- cordic_done  in  1  CORDIC final-iteration flag; the result is final on the next cycle

## Operation
- FSM states:
  - IDLE: grant allowed.
  - RUN: CORDIC iterating.
  - CAPTURE: CORDIC outputs final.
- IDLE to RUN:
  - Condition: any req_valid is high, and the response register is free (rsp_valid=0, or rsp_valid & rsp_ready in the same cycle).
  - In that cycle, combinationally: req_ready[g]=1, cordic_start=1, and the cordic_* operands are muxed from requester g.
  - On the edge, store g as the in-flight id.
- RUN to CAPTURE: on cordic_done=1. cordic_done is ignored in IDLE and CAPTURE, because the CORDIC counter free-runs and pulses done every 8 cycles when idle.
- CAPTURE to IDLE: unconditional. On the edge:
  - rsp_xout <= cordic_xout, rsp_x2out <= cordic_x2out;
  - rsp_id <= in-flight id;
  - rsp_valid <= 1.
- The response register clears when rsp_valid & rsp_ready.
- The grant rule guarantees the register is free at CAPTURE, so CAPTURE never stalls. A stall is forbidden: the CORDIC keeps iterating and would corrupt its result.
- Outside the grant cycle, cordic_start=0 and the cordic_* operands hold their last value. All req_ready bits are 0.
- Arithmetic: pass-through only; no width change or rounding.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_xout=0, rsp_x2out=0, in-flight id=0, round-robin pointer=NREQ-1. Combinational outputs: req_ready=0, cordic_start=0.
- Reset mid-operation: the in-flight operation is discarded with no response. The CORDIC needs no reset, because the next start reloads it.

## Timing
- Grant edge E0 loads the CORDIC and starts its counter at 0.
- Edges E1..E8 perform the 8 iterations.
- cordic_done is high between E7 and E8.
- CAPTURE occupies the cycle between E8 and E9.
- rsp_valid rises after E9: 9 cycles from the accept edge.
- Minimum grant-to-grant spacing is 10 cycles.
- A requester that drops req_valid before being granted is simply skipped. A request is never half-accepted.
- Simultaneous rsp_ready and a new grant in IDLE is allowed; the freed register is reused 9 cycles later.

## Configuration
- CORDIC_ARB_RR_EN defined: round-robin. The search starts at pointer+1 (mod NREQ), and the pointer updates to g on each grant.
- CORDIC_ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package cordic_arb_pkg holds:
  - the state enum {IDLE, RUN, CAPTURE};
  - CORDIC_ITERS=8;
  - the default NREQ and W.
- Sub-module rr_arbiter:
  - Combinational grant, one-hot and encoded, from the request vector and pointer.
  - Owns the pointer register under CORDIC_ARB_RR_EN.
- The top level holds the FSM, operand mux, in-flight id and response register.

## Test plan
- Single request: requester 1 presents (x=3000, y=4000, x2=1000, y2=0), connected to the real CORDIC.
  - Response: rsp_valid 9 cycles after accept, rsp_id=1.
  - rsp_xout and rsp_x2out bit-exact versus the golden CORDIC model, ≈5145 and ≈1029 respectively.
- All three requesters valid continuously, RR enabled: grants 0,1,2,0,1,2, spaced exactly 10 cycles. With RR disabled: grants 0,0,0.
- Backpressure: rsp_ready held low for 30 cycles.
  - No second grant while rsp_valid is high.
  - Pulsing rsp_ready produces a grant in that same cycle.
- Stale done: toggle request inputs while idle for 20 cycles with req_valid=0. There must be no spurious rsp_valid, even though cordic_done pulses every 8 cycles.
- Reset mid-operation: assert rst_n low during RUN.
  - All outputs return to their reset values immediately.
  - After release, a new request completes correctly with its own rsp_id.
- Withdrawal: requester 2 drops req_valid before it is granted. It is never granted, and no response with rsp_id=2 appears.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC arbiter slice:
// FSM state enum, CORDIC iteration count and default sizes.
package cordic_arb_pkg;

   localparam int CORDIC_ITERS = 8;
   localparam int NREQ_DEF     = 3;
   localparam int W_DEF        = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CAPTURE
   } state_e;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester/response bundle of the CORDIC arbiter.
// slave: arbiter side; master: requesters + result consumer.
interface cordic_arbiter_if
   import cordic_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF
) ();

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic [NREQ*W-1:0] req_x2;
   logic [NREQ*W-1:0] req_y2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_xout;
   logic [W-1:0]      rsp_x2out;

   modport slave (
      input  req_valid, req_x, req_y, req_x2, req_y2,
      output req_ready,
      output rsp_valid, rsp_id, rsp_xout, rsp_x2out,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_x, req_y, req_x2, req_y2,
      input  req_ready,
      input  rsp_valid, rsp_id, rsp_xout, rsp_x2out,
      output rsp_ready
   );

endinterface

// File: rtl/cordic_arbiter_rr_arbiter.sv
// rr_arbiter: combinational grant (one-hot + index) over req.
// CORDIC_ARB_RR_EN: round-robin from ptr+1, ptr <= grant on adv;
// otherwise fixed priority (lowest index), no pointer, no clock.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = $clog2(NREQ)
) (
`ifdef CORDIC_ARB_RR_EN
   input  logic            clk,
   input  logic            rst_n,
   input  logic            adv,
`endif
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_any
);

`ifdef CORDIC_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] sel;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      sel     = ptr_q;
      // walk ptr+1, ptr+2, ... wrapping at NREQ-1
      for (int k = 0; k < NREQ; k++) begin
         sel = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
         if (!gnt_any && req[sel]) begin
            gnt_any = 1'b1;
            gnt_idx = sel;
         end
      end
   end

   always_comb begin
      ptr_d = adv ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IW'(NREQ - 1);
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_idx = IW'(i);
            gnt_any = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_oh[i] = gnt_any && (gnt_idx == IW'(i));
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one two-channel vectoring CORDIC among NREQ
// requesters, one operation in flight, result tagged with requester id.
// Ports: clk, rst_n (async low), bus (slave: req_*/rsp_*),
// cordic_start/xin/yin/x2in/y2in out, cordic_xout/x2out/done in.
// Build option: CORDIC_ARB_RR_EN selects round-robin over fixed priority.
module cordic_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   cordic_arbiter_if.slave bus,
   output logic           cordic_start,
   output logic [W-1:0]   cordic_xin,
   output logic [W-1:0]   cordic_yin,
   output logic [W-1:0]   cordic_x2in,
   output logic [W-1:0]   cordic_y2in,
   input  logic [W-1:0]   cordic_xout,
   input  logic [W-1:0]   cordic_x2out,
   input  logic           cordic_done
);

   localparam int IW = $clog2(NREQ);

   state_e         state_q, state_d;
   logic [IW-1:0]  id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]  rsp_id_q, rsp_id_d;
   logic [W-1:0]   rsp_xout_q, rsp_xout_d;
   logic [W-1:0]   rsp_x2out_q, rsp_x2out_d;
   logic [W-1:0]   opx_q, opx_d;
   logic [W-1:0]   opy_q, opy_d;
   logic [W-1:0]   opx2_q, opx2_d;
   logic [W-1:0]   opy2_q, opy2_d;

   logic [NREQ-1:0] gnt_oh;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic            rsp_free;
   logic            grant;
   logic [W-1:0]    mx, my, mx2, my2;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
`ifdef CORDIC_ARB_RR_EN
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (grant),
`endif
      .req     (bus.req_valid),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // a response drained this cycle frees the slot for a same-cycle grant,
   // so CAPTURE can never find the register occupied
   assign rsp_free = !rsp_valid_q || bus.rsp_ready;
   assign grant    = (state_q == IDLE) && gnt_any && rsp_free;

   always_comb begin
      mx  = '0;
      my  = '0;
      mx2 = '0;
      my2 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            mx  = bus.req_x [i*W +: W];
            my  = bus.req_y [i*W +: W];
            mx2 = bus.req_x2[i*W +: W];
            my2 = bus.req_y2[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // done is only meaningful in RUN: the CORDIC counter free-runs
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant)       state_d = RUN;
         RUN:     if (cordic_done) state_d = CAPTURE;
         CAPTURE:                  state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = grant ? gnt_oh : '0;
      cordic_start  = grant;
      cordic_xin    = grant ? mx  : opx_q;
      cordic_yin    = grant ? my  : opy_q;
      cordic_x2in   = grant ? mx2 : opx2_q;
      cordic_y2in   = grant ? my2 : opy2_q;
   end

   always_comb begin
      id_d        = id_q;
      opx_d       = opx_q;
      opy_d       = opy_q;
      opx2_d      = opx2_q;
      opy2_d      = opy2_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_xout_d  = rsp_xout_q;
      rsp_x2out_d = rsp_x2out_q;
      if (grant) begin
         id_d   = gnt_idx;
         opx_d  = mx;
         opy_d  = my;
         opx2_d = mx2;
         opy2_d = my2;
      end
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
      if (state_q == CAPTURE) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = id_q;
         rsp_xout_d  = cordic_xout;
         rsp_x2out_d = cordic_x2out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q        <= '0;
         opx_q       <= '0;
         opy_q       <= '0;
         opx2_q      <= '0;
         opy2_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_xout_q  <= '0;
         rsp_x2out_q <= '0;
      end else begin
         id_q        <= id_d;
         opx_q       <= opx_d;
         opy_q       <= opy_d;
         opx2_q      <= opx2_d;
         opy2_q      <= opy2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_xout_q  <= rsp_xout_d;
         rsp_x2out_q <= rsp_x2out_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_xout  = rsp_xout_q;
   assign bus.rsp_x2out = rsp_x2out_q;

endmodule
